// File: rtl/execute_unit.sv
// Execute stage of the 4-bit processor: ALU, accumulator, C/Z flags, output
// port, pushbutton synchroniser and the shared data-bus multiplexer.
module execute_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       loadA,
    input  logic       loadFlags,
    input  logic [2:0] opALU,
    input  logic       cs,
    input  logic       we,
    input  logic       eoALU,
    input  logic       oeIn,
    input  logic       oeOprnd,
    input  logic       loadOut,
    input  logic [3:0] oprnd,
    input  logic [3:0] pushbuttons,
    input  logic [3:0] ram_rdata,
    output logic       ram_we,
    output logic [3:0] ram_wdata,
    output logic [3:0] data_bus,
    output logic [3:0] accu,
    output logic [3:0] FF_out,
    output logic       c_flag,
    output logic       z_flag,
    output logic       bus_conflict
);

    localparam int DATA_W = 4;

    logic [SYNC_STAGES-1:0][DATA_W-1:0] syncReg;
    logic [DATA_W-1:0] pbSync;
    logic [DATA_W-1:0] busIn;
    logic [DATA_W-1:0] aluY;
    logic              aluC;
    logic              aluZ;
    logic              srcConflict;

    // Returns {carry, result}; subtraction carry is the inverted borrow.
    function automatic logic [DATA_W:0] aluOp(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        case (op)
            3'b001:  r = {1'b0, a} + {1'b0, ~b} + 5'd1;
            3'b010:  r = {1'b0, b};
            3'b011:  r = {1'b0, a} + {1'b0, b};
            3'b100:  r = {1'b0, ~(a & b)};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    assign pbSync = syncReg[SYNC_STAGES-1];

    always_comb begin
        busIn = '0;
        if (oeOprnd)
            busIn = oprnd;
        else if (cs && !we)
            busIn = ram_rdata;
        else if (oeIn)
            busIn = pbSync;
    end

    assign {aluC, aluY} = aluOp(opALU, accu, busIn);
    assign aluZ         = (aluY == '0);
    assign data_bus     = eoALU ? aluY : busIn;
    assign ram_we       = cs & we & ena;
    assign ram_wdata    = accu;
    assign srcConflict  = $countones({eoALU, oeIn, oeOprnd, cs & ~we}) >= 2;

    // Synchroniser runs every cycle regardless of ena.
    always_ff @(posedge clk) begin
        if (reset) begin
            syncReg <= '0;
        end else begin
            syncReg[0] <= pushbuttons;
            for (int i = 1; i < SYNC_STAGES; i++)
                syncReg[i] <= syncReg[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            accu         <= '0;
            FF_out       <= '0;
            c_flag       <= 1'b0;
            z_flag       <= 1'b0;
            bus_conflict <= 1'b0;
        end else if (ena) begin
            if (loadA)
                accu <= aluY;
            if (loadFlags) begin
                c_flag <= aluC;
                z_flag <= aluZ;
            end
            if (loadOut)
                FF_out <= data_bus;
            if (srcConflict)
                bus_conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed vectors plus a cycle-by-cycle reference model.
`timescale 1ns/1ps
module tb_execute_unit;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset, ena, loadA, loadFlags, cs, we, eoALU, oeIn, oeOprnd, loadOut;
    logic [2:0] opALU;
    logic [3:0] oprnd, pushbuttons, ram_rdata;
    logic       ram_we, c_flag, z_flag, bus_conflict;
    logic [3:0] ram_wdata, data_bus, accu, FF_out;

    execute_unit #(.SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .ena(ena), .loadA(loadA), .loadFlags(loadFlags),
        .opALU(opALU), .cs(cs), .we(we), .eoALU(eoALU), .oeIn(oeIn),
        .oeOprnd(oeOprnd), .loadOut(loadOut), .oprnd(oprnd),
        .pushbuttons(pushbuttons), .ram_rdata(ram_rdata), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .data_bus(data_bus), .accu(accu), .FF_out(FF_out),
        .c_flag(c_flag), .z_flag(z_flag), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int  mAccu = 0, mOut = 0, mC = 0, mZ = 0, mConf = 0;
    int  pbHist[$];
    bit  mValid = 0;

    function automatic int modelBusIn();
        if (oeOprnd)               return int'(oprnd);
        else if (cs && !we)        return int'(ram_rdata);
        else if (oeIn)             return pbHist[SS-1];
        return 0;
    endfunction

    function automatic void modelAlu(input int op, input int a, input int b,
                                     output int y, output int c);
        c = 0;
        case (op)
            1: begin y = (a - b + 16) % 16; c = (a >= b) ? 1 : 0; end
            2: y = b;
            3: begin y = (a + b) % 16; c = (a + b >= 16) ? 1 : 0; end
            4: y = 15 - (a & b);
            default: y = a;
        endcase
    endfunction

    initial for (int i = 0; i < SS; i++) pbHist.push_back(0);

    always @(posedge clk) begin
        int b, y, c, bus, srcs;
        b = modelBusIn();
        modelAlu(int'(opALU), mAccu, b, y, c);
        bus  = eoALU ? y : b;
        srcs = int'(eoALU) + int'(oeIn) + int'(oeOprnd) + int'(cs && !we);
        if (reset) begin
            mAccu = 0; mOut = 0; mC = 0; mZ = 0; mConf = 0;
            for (int i = 0; i < SS; i++) pbHist[i] = 0;
            mValid = 1;
        end else begin
            if (ena) begin
                if (loadA) mAccu = y;
                if (loadFlags) begin mC = c; mZ = (y == 0) ? 1 : 0; end
                if (loadOut) mOut = bus;
                if (srcs >= 2) mConf = 1;
            end
            pbHist.push_front(int'(pushbuttons));
            void'(pbHist.pop_back());
        end
    end

    always @(negedge clk) begin
        int b, y, c;
        if (mValid) begin
            b = modelBusIn();
            modelAlu(int'(opALU), mAccu, b, y, c);
            check("cmp_data_bus", data_bus, 4'(eoALU ? y : b));
            check("cmp_ram_we", {3'b0, ram_we}, {3'b0, cs & we & ena});
            check("cmp_ram_wdata", ram_wdata, 4'(mAccu));
            check("cmp_accu", accu, 4'(mAccu));
            check("cmp_ff_out", FF_out, 4'(mOut));
            check("cmp_c_flag", {3'b0, c_flag}, 4'(mC));
            check("cmp_z_flag", {3'b0, z_flag}, 4'(mZ));
            check("cmp_conflict", {3'b0, bus_conflict}, 4'(mConf));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; ena = 1; loadA = 0; loadFlags = 0; cs = 0; we = 0;
        eoALU = 0; oeIn = 0; oeOprnd = 0; loadOut = 0; opALU = 3'b000; oprnd = 4'h0;
    endtask

    task automatic loadAccu(input logic [3:0] v);
        idle(); oeOprnd = 1; oprnd = v; opALU = 3'b010; loadA = 1;
        tick(); idle();
    endtask

    initial begin
        pushbuttons = 4'h0; ram_rdata = 4'h0;
        idle();
        // reset with every load and a conflicting bus request asserted
        reset = 1; loadA = 1; loadFlags = 1; loadOut = 1; eoALU = 1;
        oeOprnd = 1; oprnd = 4'hF; opALU = 3'b011;
        tick(); idle();
        check("reset_accu", accu, 4'h0);
        check("reset_ffout", FF_out, 4'h0);
        check("reset_flags", {2'b0, c_flag, z_flag}, 4'h0);
        check("reset_conflict", {3'b0, bus_conflict}, 4'h0);

        // add with wrap
        loadAccu(4'h9);
        oeOprnd = 1; oprnd = 4'h8; opALU = 3'b011; loadA = 1; loadFlags = 1;
        tick(); idle();
        check("add_wrap_accu", accu, 4'h1);
        check("add_wrap_cz", {2'b0, c_flag, z_flag}, 4'b0010);
        loadAccu(4'h9);
        oeOprnd = 1; oprnd = 4'h7; opALU = 3'b011; loadA = 1; loadFlags = 1;
        tick(); idle();
        check("add_zero_accu", accu, 4'h0);
        check("add_zero_cz", {2'b0, c_flag, z_flag}, 4'b0011);

        // subtract / compare, flags only
        loadAccu(4'h3);
        oeOprnd = 1; oprnd = 4'h5; opALU = 3'b001; loadFlags = 1;
        tick(); idle();
        check("cmp_lt_cz", {2'b0, c_flag, z_flag}, 4'b0000);
        check("cmp_lt_accu", accu, 4'h3);
        oeOprnd = 1; oprnd = 4'h3; opALU = 3'b001; loadFlags = 1;
        tick(); idle();
        check("cmp_eq_cz", {2'b0, c_flag, z_flag}, 4'b0011);

        // RAM path
        loadAccu(4'hA);
        cs = 1; we = 1;
        #1;
        check("store_we", {3'b0, ram_we}, 4'h1);
        check("store_wdata", ram_wdata, 4'hA);
        tick(); idle();
        cs = 1; we = 0; ram_rdata = 4'h6; opALU = 3'b010; loadA = 1;
        tick(); idle();
        check("load_ram_accu", accu, 4'h6);
        ena = 0; cs = 1; we = 1; oeOprnd = 1; oprnd = 4'hF; opALU = 3'b010; loadA = 1;
        #1;
        check("ena0_ram_we", {3'b0, ram_we}, 4'h0);
        tick(); idle();
        check("ena0_accu_held", accu, 4'h6);

        // store in the same cycle as loadA writes the old accu
        cs = 1; we = 1; oeOprnd = 1; oprnd = 4'h4; opALU = 3'b010; loadA = 1;
        #1;
        check("store_old_accu", ram_wdata, 4'h6);
        tick(); idle();
        check("store_new_accu", accu, 4'h4);

        // NAND and reserved opcode
        oeOprnd = 1; oprnd = 4'h5; opALU = 3'b100; loadA = 1;
        tick(); idle();
        check("nand_accu", accu, 4'hB);
        oeOprnd = 1; oprnd = 4'h0; opALU = 3'b110; loadA = 1; loadFlags = 1;
        tick(); idle();
        check("rsvd_accu", accu, 4'hB);
        check("rsvd_cz", {2'b0, c_flag, z_flag}, 4'b0000);

        // input / output
        pushbuttons = 4'hC;
        oeIn = 1;
        tick(SS - 1);
        check("sync_not_yet", data_bus, 4'h0);
        tick();
        loadOut = 1;
        #1;
        check("sync_bus", data_bus, 4'hC);
        tick(); idle();
        check("ffout_pb", FF_out, 4'hC);
        eoALU = 1; opALU = 3'b000; loadOut = 1;
        tick(); idle();
        check("ffout_accu", FF_out, 4'hB);

        // conflict suppressed by ena = 0, then set and sticky
        ena = 0; oeIn = 1; oeOprnd = 1; oprnd = 4'h2;
        tick();
        check("conflict_ena0", {3'b0, bus_conflict}, 4'h0);
        ena = 1;
        #1;
        check("conflict_bus", data_bus, 4'h2);
        tick(); idle();
        check("conflict_set", {3'b0, bus_conflict}, 4'h1);
        tick(3);
        check("conflict_sticky", {3'b0, bus_conflict}, 4'h1);
        reset = 1;
        tick(); idle();
        check("conflict_reset", {3'b0, bus_conflict}, 4'h0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
